dcom_buffer_loader: RTL and testbench

DCOM_BUFFER_LOADER -- requirements
Module: dcom_buffer_loader

---
 rtl/dcom_buffer_loader_pkg.sv | 21 ++
 rtl/dcom_buffer_loader.sv | 123 ++++++++++++
 tb/tb_dcom_buffer_loader.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcom_buffer_loader_pkg.sv
// rtl/dcom_buffer_loader_pkg.sv - widths, FSM states and byte-enable helper for the buffer loader
package dcom_buffer_loader_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 64;
   localparam int BE_W   = 8;
   localparam int CNT_W  = 13;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DATA,
      WRITE,
      DONE
   } state_t;

   // An all-zero final byteenable would write nothing, so it means "whole word".
   function automatic logic [BE_W-1:0] eff_last_be(input logic [BE_W-1:0] be);
      return (be == '0) ? '1 : be;
   endfunction

endpackage

// File: rtl/dcom_buffer_loader.sv
// rtl/dcom_buffer_loader.sv - streams a counted run of 64-bit words into the dcom data buffer over Avalon-MM
module dcom_buffer_loader
   import dcom_buffer_loader_pkg::*;
(
   input  logic              clock_sink_clk,
   input  logic              reset_sink_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_start_addr,
   input  logic [CNT_W-1:0]  cmd_word_cnt,
   input  logic [BE_W-1:0]   cmd_last_be,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [DATA_W-1:0] data_word,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   output logic [BE_W-1:0]   avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic              abort,
   input  logic              irq_clear,
   output logic              busy,
   output logic              done_irq,
   output logic              wrap_flag,
   output logic              aborted
);

   state_t            state;
   logic [CNT_W-1:0]  remaining;
   logic [BE_W-1:0]   last_be;
   logic              abort_pending;
   logic              stop_req;
   logic              data_fire;

   assign stop_req  = abort || abort_pending;
   // abort outranks a command offered in the same cycle
   assign cmd_ready = (state == IDLE) && (!abort || reset_sink_reset);
   // Accepting in WRITE while the current word completes keeps the bus at one word per cycle.
   assign data_ready = ((state == WAIT_DATA) && !abort) ||
                       ((state == WRITE) && !avm_waitrequest &&
                        (remaining > CNT_W'(1)) && !stop_req);
   assign data_fire = data_valid && data_ready;
   assign busy      = (state == WAIT_DATA) || (state == WRITE);

   always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
      if (reset_sink_reset) begin
         state          <= IDLE;
         remaining      <= '0;
         last_be        <= '0;
         abort_pending  <= 1'b0;
         avm_address    <= '0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
         done_irq       <= 1'b0;
         wrap_flag      <= 1'b0;
         aborted        <= 1'b0;
      end else begin
         if (state == DONE)
            done_irq <= 1'b1;
         else if (irq_clear)
            done_irq <= 1'b0;

         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  avm_address   <= cmd_start_addr;
                  remaining     <= cmd_word_cnt;
                  last_be       <= eff_last_be(cmd_last_be);
                  wrap_flag     <= 1'b0;
                  aborted       <= 1'b0;
                  abort_pending <= 1'b0;
                  state         <= (cmd_word_cnt == '0) ? DONE : WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= IDLE;
               end else if (data_fire) begin
                  avm_writedata  <= data_word;
                  avm_byteenable <= (remaining == CNT_W'(1)) ? last_be : '1;
                  avm_write      <= 1'b1;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               if (abort)
                  abort_pending <= 1'b1;
               // A write in flight cannot be withdrawn, so abort waits for completion.
               if (!avm_waitrequest) begin
                  remaining   <= remaining - CNT_W'(1);
                  avm_address <= avm_address + ADDR_W'(1);
                  if (avm_address == '1)
                     wrap_flag <= 1'b1;
                  if (stop_req) begin
                     avm_write     <= 1'b0;
                     aborted       <= 1'b1;
                     abort_pending <= 1'b0;
                     state         <= IDLE;
                  end else if (remaining == CNT_W'(1)) begin
                     avm_write <= 1'b0;
                     state     <= DONE;
                  end else if (data_fire) begin
                     avm_writedata  <= data_word;
                     avm_byteenable <= (remaining == CNT_W'(2)) ? last_be : '1;
                  end else begin
                     avm_write <= 1'b0;
                     state     <= WAIT_DATA;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcom_buffer_loader.sv
// tb/tb_dcom_buffer_loader.sv - self-checking bench for dcom_buffer_loader
module tb_dcom_buffer_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [11:0] cmd_start_addr = '0;
   logic [12:0] cmd_word_cnt = '0;
   logic [7:0]  cmd_last_be = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [63:0] data_word = '0;
   logic [11:0] avm_address;
   logic        avm_write;
   logic [63:0] avm_writedata;
   logic [7:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic        abort = 1'b0;
   logic        irq_clear = 1'b0;
   logic        busy, done_irq, wrap_flag, aborted;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // stimulus knobs
   bit prod_en = 0;
   int valid_pct = 100;
   int wr_mode = 0;
   int stall_idx = 0;
   int stall_left = 0;

   // monitor record
   logic [11:0] xa_q[$];
   logic [63:0] xd_q[$];
   logic [7:0]  xb_q[$];
   int          xc_q[$];
   logic [63:0] acc_q[$];
   int          hold_err = 0;
   int          wr_cycles = 0;
   bit          fired = 0;
   bit          hold_prev = 0;
   logic [11:0] h_a;
   logic [63:0] h_d;
   logic [7:0]  h_b;

   dcom_buffer_loader dut (
      .clock_sink_clk  (clk),
      .reset_sink_reset(rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_start_addr  (cmd_start_addr),
      .cmd_word_cnt    (cmd_word_cnt),
      .cmd_last_be     (cmd_last_be),
      .data_valid      (data_valid),
      .data_ready      (data_ready),
      .data_word       (data_word),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .abort           (abort),
      .irq_clear       (irq_clear),
      .busy            (busy),
      .done_irq        (done_irq),
      .wrap_flag       (wrap_flag),
      .aborted         (aborted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 0;
      end else begin
         if (data_valid && data_ready) begin
            acc_q.push_back(data_word);
            fired = 1;
         end
         if (avm_write) wr_cycles++;
         if (hold_prev && (avm_address !== h_a || avm_writedata !== h_d || avm_byteenable !== h_b))
            hold_err++;
         hold_prev = avm_write && avm_waitrequest;
         h_a = avm_address;
         h_d = avm_writedata;
         h_b = avm_byteenable;
         if (avm_write && !avm_waitrequest) begin
            xa_q.push_back(avm_address);
            xd_q.push_back(avm_writedata);
            xb_q.push_back(avm_byteenable);
            xc_q.push_back(cyc);
         end
      end
   end

   // word producer: holds a word until it is taken
   always @(posedge clk) begin
      #1;
      if (!prod_en) begin
         data_valid = 1'b0;
         fired = 0;
      end else if (fired || !data_valid) begin
         data_valid = ($urandom_range(99) < valid_pct);
         data_word  = {$urandom, $urandom};
         fired = 0;
      end
   end

   // slave model: 0 = never stall, 1 = random stall, 2 = stall word stall_idx for stall_left cycles
   always @(posedge clk) begin
      #1;
      if (wr_mode == 0)
         avm_waitrequest = 1'b0;
      else if (wr_mode == 1)
         avm_waitrequest = ($urandom_range(99) < 40);
      else if (avm_write && xa_q.size() == stall_idx && stall_left > 0) begin
         avm_waitrequest = 1'b1;
         stall_left--;
      end else
         avm_waitrequest = 1'b0;
   end

   // reference model: word i of a command
   function automatic logic [11:0] exp_addr(input logic [11:0] a, input int i);
      return 12'((int'(a) + i) % 4096);
   endfunction

   function automatic logic [7:0] exp_be(input logic [7:0] be, input int i, input int n);
      if (i != n - 1) return 8'hFF;
      return (be == 8'h00) ? 8'hFF : be;
   endfunction

   task automatic prep();
      prod_en = 0;
      @(posedge clk); #1;
      irq_clear = 1'b1;
      @(posedge clk); #1;
      irq_clear = 1'b0;
      xa_q.delete(); xd_q.delete(); xb_q.delete(); xc_q.delete(); acc_q.delete();
      hold_err = 0;
      wr_cycles = 0;
   endtask

   task automatic issue_cmd(input logic [11:0] a, input logic [12:0] n, input logic [7:0] be,
                            output int acc_cyc, output bit ok);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_start_addr = a;
      cmd_word_cnt = n;
      cmd_last_be = be;
      ok = 0;
      acc_cyc = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL cmd_accept: cmd_ready never seen, required 1 within 50 cycles");
      end
   endtask

   task automatic wait_irq(input int budget, output int irq_cyc, output bit ok);
      ok = 0;
      irq_cyc = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done_irq) begin
            ok = 1;
            irq_cyc = cyc;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL irq_timeout: done_irq=0 after %0d cycles, required 1", budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, avm_write, data_ready, busy, done_irq, wrap_flag, aborted} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_status: got %b, required 1000000",
                  {cmd_ready, avm_write, data_ready, busy, done_irq, wrap_flag, aborted});
      end
      checks++;
      if ({avm_address, avm_writedata, avm_byteenable} !== 84'd0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h data=%h be=%h, required all 0", avm_address, avm_writedata, avm_byteenable);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int ac, ic;
      bit ok;
      prep();
      wr_mode = 0; valid_pct = 100; prod_en = 1;
      issue_cmd(12'h010, 13'd4, 8'h0F, ac, ok);
      wait_irq(100, ic, ok);
      prod_en = 0;
      checks++;
      if (xa_q.size() != 4 || acc_q.size() != 4) begin
         errors++;
         $display("FAIL basic_count: transfers=%0d accepted=%0d, required 4", xa_q.size(), acc_q.size());
      end
      for (int i = 0; i < 4 && i < xa_q.size() && i < acc_q.size(); i++) begin
         checks++;
         if (xa_q[i] !== exp_addr(12'h010, i) || xd_q[i] !== acc_q[i] || xb_q[i] !== exp_be(8'h0F, i, 4)) begin
            errors++;
            $display("FAIL basic_word%0d: addr=%h data=%h be=%h, required addr=%h data=%h be=%h", i,
                     xa_q[i], xd_q[i], xb_q[i], exp_addr(12'h010, i), acc_q[i], exp_be(8'h0F, i, 4));
         end
      end
      checks++;
      if (xc_q.size() != 4 || xc_q[3] - xc_q[0] != 3) begin
         errors++;
         $display("FAIL basic_back_to_back: %0d transfers not on 4 consecutive cycles", xc_q.size());
      end
      checks++;
      if (xc_q.size() == 0 || ic != xc_q[xc_q.size()-1] + 2) begin
         errors++;
         $display("FAIL basic_irq_cycle: irq at cycle %0d, required last write cycle + 2", ic);
      end
      checks++;
      if (wrap_flag !== 1'b0 || aborted !== 1'b0) begin
         errors++;
         $display("FAIL basic_flags: wrap=%b aborted=%b, required 0 0", wrap_flag, aborted);
      end
   endtask

   task automatic test_stall();
      int ac, ic;
      bit ok;
      prep();
      wr_mode = 2; stall_idx = 1; stall_left = 3; valid_pct = 100; prod_en = 1;
      issue_cmd(12'h010, 13'd4, 8'h0F, ac, ok);
      wait_irq(100, ic, ok);
      prod_en = 0;
      checks++;
      if (xa_q.size() != 4 || acc_q.size() != 4) begin
         errors++;
         $display("FAIL stall_count: transfers=%0d accepted=%0d, required 4", xa_q.size(), acc_q.size());
      end
      for (int i = 0; i < 4 && i < xa_q.size() && i < acc_q.size(); i++) begin
         checks++;
         if (xa_q[i] !== exp_addr(12'h010, i) || xd_q[i] !== acc_q[i] || xb_q[i] !== exp_be(8'h0F, i, 4)) begin
            errors++;
            $display("FAIL stall_word%0d: addr=%h data=%h be=%h, required addr=%h data=%h be=%h", i,
                     xa_q[i], xd_q[i], xb_q[i], exp_addr(12'h010, i), acc_q[i], exp_be(8'h0F, i, 4));
         end
      end
      checks++;
      if (hold_err != 0 || wr_cycles != 7) begin
         errors++;
         $display("FAIL stall_hold: hold_errors=%0d write_cycles=%0d, required 0 and 7", hold_err, wr_cycles);
      end
   endtask

   task automatic test_wrap();
      int ac, ic;
      bit ok;
      prep();
      wr_mode = 0; valid_pct = 100; prod_en = 1;
      issue_cmd(12'hFFE, 13'd3, 8'h00, ac, ok);
      wait_irq(100, ic, ok);
      prod_en = 0;
      checks++;
      if (xa_q.size() != 3 || acc_q.size() != 3) begin
         errors++;
         $display("FAIL wrap_count: transfers=%0d accepted=%0d, required 3", xa_q.size(), acc_q.size());
      end
      for (int i = 0; i < 3 && i < xa_q.size() && i < acc_q.size(); i++) begin
         checks++;
         if (xa_q[i] !== exp_addr(12'hFFE, i) || xd_q[i] !== acc_q[i] || xb_q[i] !== exp_be(8'h00, i, 3)) begin
            errors++;
            $display("FAIL wrap_word%0d: addr=%h be=%h, required addr=%h be=%h", i,
                     xa_q[i], xb_q[i], exp_addr(12'hFFE, i), exp_be(8'h00, i, 3));
         end
      end
      checks++;
      if (wrap_flag !== 1'b1) begin
         errors++;
         $display("FAIL wrap_flag: got %b, required 1", wrap_flag);
      end
   endtask

   task automatic test_zero_count();
      int ac, ic;
      bit ok;
      prep();
      wr_mode = 0;
      issue_cmd(12'h123, 13'd0, 8'hAA, ac, ok);
      wait_irq(20, ic, ok);
      checks++;
      if (ic != ac + 2 || wr_cycles != 0) begin
         errors++;
         $display("FAIL zero_cnt: irq cycle offset=%0d writes=%0d, required 2 and 0", ic - ac, wr_cycles);
      end
      @(posedge clk); #1;
      irq_clear = 1'b1;
      issue_cmd(12'h124, 13'd0, 8'h00, ac, ok);
      @(negedge clk);
      checks++;
      if (done_irq !== 1'b0) begin
         errors++;
         $display("FAIL zero_clear_before_done: done_irq=%b, required 0", done_irq);
      end
      @(posedge clk); #1;
      irq_clear = 1'b0;
      @(negedge clk);
      checks++;
      if (done_irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set_wins: done_irq=%b, required 1", done_irq);
      end
      @(posedge clk); #1;
      irq_clear = 1'b1;
      @(posedge clk); #1;
      irq_clear = 1'b0;
      @(negedge clk);
      checks++;
      if (done_irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: done_irq=%b, required 0", done_irq);
      end
   endtask

   task automatic test_abort_write();
      int ac;
      bit ok, seen;
      prep();
      wr_mode = 2; stall_idx = 1; stall_left = 1000; valid_pct = 100; prod_en = 1;
      issue_cmd(12'h200, 13'd4, 8'h3C, ac, ok);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = avm_write && (xa_q.size() == 1);
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      repeat (2) @(posedge clk);
      #1 stall_left = 0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      prod_en = 0;
      checks++;
      if (!seen || xa_q.size() != 2 || acc_q.size() != 2) begin
         errors++;
         $display("FAIL abort_count: stalled=%0d transfers=%0d accepted=%0d, required 1 2 2",
                  seen, xa_q.size(), acc_q.size());
      end
      for (int i = 0; i < 2 && i < xa_q.size() && i < acc_q.size(); i++) begin
         checks++;
         if (xa_q[i] !== exp_addr(12'h200, i) || xd_q[i] !== acc_q[i] || xb_q[i] !== 8'hFF) begin
            errors++;
            $display("FAIL abort_word%0d: addr=%h be=%h, required addr=%h be=ff", i,
                     xa_q[i], xb_q[i], exp_addr(12'h200, i));
         end
      end
      checks++;
      if ({aborted, done_irq, busy, cmd_ready, hold_err == 0} !== 5'b10011) begin
         errors++;
         $display("FAIL abort_status: aborted=%b irq=%b busy=%b cmd_ready=%b hold_errors=%0d, required 1 0 0 1 0",
                  aborted, done_irq, busy, cmd_ready, hold_err);
      end
   endtask

   task automatic test_abort_wait();
      int ac;
      bit ok;
      prep();
      wr_mode = 0;
      issue_cmd(12'h300, 13'd2, 8'hFF, ac, ok);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || data_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_state: busy=%b data_ready=%b, required 1 1", busy, data_ready);
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, aborted, done_irq} !== 3'b010 || xa_q.size() != 0) begin
         errors++;
         $display("FAIL abort_wait: busy=%b aborted=%b irq=%b transfers=%0d, required 0 1 0 0",
                  busy, aborted, done_irq, xa_q.size());
      end
      @(posedge clk); #1;
      abort = 1'b1;
      cmd_valid = 1'b1;
      cmd_word_cnt = 13'd1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: cmd_ready=%b, required 0", cmd_ready);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || aborted !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle_ignored: busy=%b aborted=%b, required 0 1", busy, aborted);
      end
   endtask

   task automatic test_reset_mid();
      int ac;
      bit ok, seen;
      prep();
      wr_mode = 2; stall_idx = 0; stall_left = 1000; valid_pct = 100; prod_en = 1;
      issue_cmd(12'h400, 13'd3, 8'h01, ac, ok);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = avm_write;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (!seen || avm_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: write_seen=%0d avm_write=%b after reset, required 1 and 0", seen, avm_write);
      end
      stall_left = 0;
      prod_en = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({cmd_ready, avm_write, busy, done_irq, wrap_flag, aborted} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_release: got %b, required 100000",
                  {cmd_ready, avm_write, busy, done_irq, wrap_flag, aborted});
      end
   endtask

   task automatic test_random();
      int ac, ic, n;
      bit ok, exp_wrap;
      logic [11:0] a;
      logic [7:0] be;
      for (int k = 0; k < 25; k++) begin
         prep();
         a = ($urandom_range(3) == 0) ? 12'(4088 + $urandom_range(7)) : 12'($urandom);
         n = $urandom_range(12, 1);
         be = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
         wr_mode = 1;
         valid_pct = $urandom_range(100, 30);
         prod_en = 1;
         issue_cmd(a, 13'(n), be, ac, ok);
         wait_irq(600, ic, ok);
         prod_en = 0;
         exp_wrap = (int'(a) + n - 1) >= 4095;
         checks++;
         if (xa_q.size() != n || acc_q.size() != n || hold_err != 0) begin
            errors++;
            $display("FAIL rand%0d_count: transfers=%0d accepted=%0d hold_errors=%0d, required %0d %0d 0",
                     k, xa_q.size(), acc_q.size(), hold_err, n, n);
         end
         for (int i = 0; i < n && i < xa_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (xa_q[i] !== exp_addr(a, i) || xd_q[i] !== acc_q[i] || xb_q[i] !== exp_be(be, i, n)) begin
               errors++;
               $display("FAIL rand%0d_word%0d: addr=%h data=%h be=%h, required addr=%h data=%h be=%h", k, i,
                        xa_q[i], xd_q[i], xb_q[i], exp_addr(a, i), acc_q[i], exp_be(be, i, n));
            end
         end
         checks++;
         if (wrap_flag !== exp_wrap || xc_q.size() == 0 || ic != xc_q[xc_q.size()-1] + 2) begin
            errors++;
            $display("FAIL rand%0d_flags: wrap=%b irq_cycle=%0d, required wrap=%b irq at last write + 2",
                     k, wrap_flag, ic, exp_wrap);
         end
      end
      wr_mode = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_zero_count();
      test_abort_write();
      test_abort_wait();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
